// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial RAM controller: port status codes,
// machine word sizes and the requester identity type.
package mem_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;
  localparam int REG_LEN  = 32;

  localparam logic [1:0] STAT_IDLE = 2'b00;
  localparam logic [1:0] STAT_BUSY = 2'b01;
  localparam logic [1:0] STAT_DONE = 2'b10;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LS = 1'b1
  } port_e;

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating a fetch port and a load/store port onto an 8-bit bus.
// Optional MEM_CTRL_STAT_EN adds per-port completion counters; otherwise they read 0.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_AW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_rw,
  input  logic [ADDR_LEN-1:0] if_addr,
  output logic [INST_LEN-1:0] if_data,
  output logic [1:0]          if_status,
  input  logic                ls_rw,
  input  logic                ls_we,
  input  logic [1:0]          ls_width,
  input  logic [ADDR_LEN-1:0] ls_addr,
  input  logic [REG_LEN-1:0]  ls_wdata,
  output logic [REG_LEN-1:0]  ls_rdata,
  output logic [1:0]          ls_status,
  output logic [RAM_AW-1:0]   ram_a,
  output logic                ram_wr,
  output logic [7:0]          ram_dout,
  input  logic [7:0]          ram_din,
  output logic [31:0]         stat_if_cnt,
  output logic [31:0]         stat_ls_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] W_ILLEGAL = 2'd2;
  localparam logic [1:0] W_WORD    = 2'd3;

  state_e              state_q;
  port_e               port_q;
  logic [31:0]         base_q;
  logic [31:0]         wdata_q;
  logic [1:0]          last_q;
  logic [2:0]          beat_q;
  logic [7:0]          lane_q [4];
  logic [31:0]         if_data_q;
  logic [31:0]         ls_rdata_q;
  logic [1:0]          if_status_q;
  logic [1:0]          ls_status_q;
  logic [RAM_AW-1:0]   ram_a_q;
  logic                ram_wr_q;
  logic [7:0]          ram_dout_q;
  logic [31:0]         rd_word_d;
  logic [1:0]          next_k_d;

  function automatic logic [RAM_AW-1:0] beat_addr(input logic [31:0] base, input logic [1:0] k);
    logic [31:0] sum;
    sum = base + {30'd0, k};
    return sum[RAM_AW-1:0];
  endfunction

  function automatic logic [1:0] last_beat(input logic [1:0] w);
    return (w == W_ILLEGAL) ? W_WORD : w;
  endfunction

  // Final byte arrives on ram_din in the drain cycle; merge it with the lanes already captured.
  always_comb begin
    rd_word_d = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};
    rd_word_d[{last_q, 3'b000} +: 8] = ram_din;
  end

  assign next_k_d = beat_q[1:0] + 2'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      if_status_q <= STAT_IDLE;
      ls_status_q <= STAT_IDLE;
      if_data_q   <= '0;
      ls_rdata_q  <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          beat_q <= '0;
          for (int i = 0; i < 4; i++) lane_q[i] <= '0;
          if (ls_rw) begin
            port_q      <= PORT_LS;
            base_q      <= ls_addr;
            wdata_q     <= ls_wdata;
            last_q      <= last_beat(ls_width);
            ram_a_q     <= beat_addr(ls_addr, 2'd0);
            ls_status_q <= STAT_BUSY;
            if (ls_we) begin
              state_q    <= S_WRITE;
              ram_wr_q   <= 1'b1;
              ram_dout_q <= ls_wdata[7:0];
            end else begin
              state_q <= S_READ;
            end
          end else if (if_rw) begin
            port_q      <= PORT_IF;
            base_q      <= if_addr;
            last_q      <= W_WORD;
            ram_a_q     <= beat_addr(if_addr, 2'd0);
            if_status_q <= STAT_BUSY;
            state_q     <= S_READ;
          end
        end
        // beat_q counts issued addresses; byte beat_q-1 is on ram_din this cycle
        S_READ: begin
          if (beat_q != 3'd0) lane_q[beat_q[1:0] - 2'd1] <= ram_din;
          if (beat_q == {1'b0, last_q} + 3'd1) begin
            state_q <= S_DONE;
            if (port_q == PORT_LS) begin
              ls_rdata_q  <= rd_word_d;
              ls_status_q <= STAT_DONE;
            end else begin
              if_data_q   <= rd_word_d;
              if_status_q <= STAT_DONE;
            end
          end else begin
            beat_q <= beat_q + 3'd1;
            if (beat_q < {1'b0, last_q}) ram_a_q <= beat_addr(base_q, next_k_d);
          end
        end
        S_WRITE: begin
          if (beat_q[1:0] == last_q) begin
            ram_wr_q    <= 1'b0;
            state_q     <= S_DONE;
            ls_status_q <= STAT_DONE;
          end else begin
            beat_q     <= beat_q + 3'd1;
            ram_a_q    <= beat_addr(base_q, next_k_d);
            ram_dout_q <= wdata_q[{next_k_d, 3'b000} +: 8];
          end
        end
        default: begin
          state_q     <= S_IDLE;
          if_status_q <= STAT_IDLE;
          ls_status_q <= STAT_IDLE;
        end
      endcase
    end
  end

  assign if_data   = if_data_q;
  assign ls_rdata  = ls_rdata_q;
  assign if_status = if_status_q;
  assign ls_status = ls_status_q;
  assign ram_a     = ram_a_q;
  assign ram_wr    = ram_wr_q;
  assign ram_dout  = ram_dout_q;

`ifdef MEM_CTRL_STAT_EN
  logic [31:0] stat_if_q;
  logic [31:0] stat_ls_q;

  // S_DONE lasts exactly one cycle, so each completion is counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_if_q <= '0;
      stat_ls_q <= '0;
    end else if (state_q == S_DONE) begin
      if (port_q == PORT_IF) stat_if_q <= stat_if_q + 32'd1;
      else                   stat_ls_q <= stat_ls_q + 32'd1;
    end
  end

  assign stat_if_cnt = stat_if_q;
  assign stat_ls_cnt = stat_ls_q;
`else
  assign stat_if_cnt = 32'h0;
  assign stat_ls_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: RAM model on the byte bus, byte-array reference memory,
// directed scenarios followed by randomized fetch / load / store traffic.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_rw;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic [1:0]  if_status;
  logic        ls_rw;
  logic        ls_we;
  logic [1:0]  ls_width;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic [31:0] ls_rdata;
  logic [1:0]  ls_status;
  logic [31:0] ram_a;
  logic        ram_wr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din;
  logic [31:0] stat_if_cnt;
  logic [31:0] stat_ls_cnt;

  always #5 clk = ~clk;

  mem_ctrl #(.RAM_AW(32)) dut (
    .clk(clk), .rst(rst),
    .if_rw(if_rw), .if_addr(if_addr), .if_data(if_data), .if_status(if_status),
    .ls_rw(ls_rw), .ls_we(ls_we), .ls_width(ls_width), .ls_addr(ls_addr),
    .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_status(ls_status),
    .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din),
    .stat_if_cnt(stat_if_cnt), .stat_ls_cnt(stat_ls_cnt)
  );

  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  // Bus-side RAM: 64 KiB decoded from the low address bits, read data one cycle late.
  logic [7:0] ram_mem [0:65535];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 65536; i++) ram_mem[i] <= pat(i[15:0]);
    end else if (ram_wr) begin
      ram_mem[ram_a[15:0]] <= ram_dout;
    end
    ram_din <= ram_mem[ram_a[15:0]];
  end

  // Reference memory and expectations
  logic [7:0]  mmem [0:65535];
  logic [31:0] last_ld;
  int          n_if, n_ls;
  typedef struct { bit is_ls; logic [31:0] data; } exp_t;
  exp_t        sb[$];
  logic [39:0] wr_log[$];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] m_load(input logic [31:0] a, input int n);
    logic [31:0] r, ak;
    r = '0;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      r[8*k +: 8] = mmem[ak[15:0]];
    end
    return r;
  endfunction

  task automatic m_store(input logic [31:0] a, input logic [31:0] d, input int n);
    logic [31:0] ak;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      mmem[ak[15:0]] = d[8*k +: 8];
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic check_done(input bit is_ls, input logic [31:0] data);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_done: port %0d reported DONE, expected no DONE", is_ls);
    end else begin
      e = sb.pop_front();
      chk("done_port", {31'd0, is_ls}, {31'd0, e.is_ls});
      chk(is_ls ? "ls_data" : "if_data", data, e.data);
    end
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (ram_wr) wr_log.push_back({ram_a, ram_dout});
      if (ls_status == STAT_DONE) check_done(1'b1, ls_rdata);
      if (if_status == STAT_DONE) check_done(1'b0, if_data);
    end
  endtask

  // Issue one or both requests in the same cycle (cycle 0) and follow them to DONE.
  task automatic run(input bit do_if, input logic [31:0] ia, input bit do_ls,
                     input bit we, input logic [1:0] w, input logic [31:0] la,
                     input logic [31:0] wd);
    int n, lat_ls, if_start, exp_if, t_ls, t_if;
    bit seq_bad;
    exp_t e;
    n        = (w == 2'd2) ? 4 : int'(w) + 1;
    lat_ls   = we ? n + 1 : n + 2;
    if_start = do_ls ? lat_ls + 2 : 1;
    exp_if   = if_start + 5;
    if (do_ls) begin
      e.is_ls = 1'b1;
      if (we) begin
        m_store(la, wd, n);
        e.data = last_ld;
      end else begin
        e.data  = m_load(la, n);
        last_ld = e.data;
      end
      sb.push_back(e);
      n_ls++;
    end
    if (do_if) begin
      e.is_ls = 1'b0;
      e.data  = m_load(ia, 4);
      sb.push_back(e);
      n_if++;
    end
    @(posedge clk);
    #1;
    wr_log.delete();
    if_rw = do_if;  if_addr = ia;
    ls_rw = do_ls;  ls_we = we;  ls_width = w;  ls_addr = la;  ls_wdata = wd;
    t_ls = -1;  t_if = -1;  seq_bad = 1'b0;
    for (int t = 0; t < 40 && ((do_if && t_if < 0) || (do_ls && t_ls < 0)); t++) begin
      @(negedge clk);
      if (do_ls && t_ls < 0) begin
        if (ls_status == STAT_DONE) begin
          t_ls = t;
          ls_rw = 1'b0;
        end else if ((t >= 1) != (ls_status == STAT_BUSY)) seq_bad = 1'b1;
      end
      if (do_if && t_if < 0) begin
        if (if_status == STAT_DONE) begin
          t_if = t;
          if_rw = 1'b0;
        end else if ((t >= if_start) != (if_status == STAT_BUSY)) seq_bad = 1'b1;
      end
      if (ls_status == STAT_BUSY) begin
        ls_we = $urandom;  ls_width = $urandom;  ls_addr = $urandom;  ls_wdata = $urandom;
      end
      if (if_status == STAT_BUSY) if_addr = $urandom;
    end
    if (do_ls) chk("ls_done_cycle", t_ls, lat_ls);
    if (do_if) chk("if_done_cycle", t_if, exp_if);
    chk("status_sequence", {31'd0, seq_bad}, 32'd0);
    if (do_ls && we) chk("store_beats", wr_log.size(), n);
    else             chk("read_no_write", wr_log.size(), 0);
    @(negedge clk);
    chk("idle_after_done", {28'd0, if_status, ls_status}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d;
    int kind;
    rst = 1'b1;  ram_init = 1'b1;
    if_rw = 1'b0;  if_addr = '0;
    ls_rw = 1'b0;  ls_we = 1'b0;  ls_width = '0;  ls_addr = '0;  ls_wdata = '0;
    for (int i = 0; i < 65536; i++) mmem[i] = pat(i[15:0]);
    last_ld = '0;  n_if = 0;  n_ls = 0;
    fork
      monitor();
    join_none
    repeat (2) @(posedge clk);
    #1 ram_init = 1'b0;
    @(negedge clk);
    chk("rst_if_status", {30'd0, if_status}, {30'd0, STAT_IDLE});
    chk("rst_ls_status", {30'd0, ls_status}, {30'd0, STAT_IDLE});
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_ls_rdata", ls_rdata, 32'h0);
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_wr", {31'd0, ram_wr}, 32'h0);
    chk("rst_ram_dout", {24'd0, ram_dout}, 32'h0);
    chk("rst_stat_if", stat_if_cnt, 32'h0);
    chk("rst_stat_ls", stat_ls_cnt, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Instruction word 13 05 00 00 placed at 0x1000, then fetched
    run(1'b0, 32'h0, 1'b1, 1'b1, 2'd3, 32'h1000, 32'h0000_0513);
    run(1'b1, 32'h1000, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("fetch_word", if_data, 32'h0000_0513);

    // Simultaneous requests: load/store wins, fetch follows
    run(1'b1, 32'h1000, 1'b1, 1'b0, 2'd3, 32'h2000, 32'h0);

    // Single byte store: one write strobe with the low byte
    run(1'b0, 32'h0, 1'b1, 1'b1, 2'd0, 32'h3001, 32'hAABB_CCDD);
    chk("sb_bus", (wr_log.size() > 0) ? wr_log[0][39:8] : 32'hX, 32'h3001);
    chk("sb_byte", (wr_log.size() > 0) ? {24'd0, wr_log[0][7:0]} : 32'hX, 32'h0000_00DD);

    // Halfword round trip and fetch across the top of the address space
    run(1'b0, 32'h0, 1'b1, 1'b1, 2'd1, 32'h4002, 32'h0000_1234);
    run(1'b0, 32'h0, 1'b1, 1'b0, 2'd1, 32'h4002, 32'h0);
    chk("lh_zero_ext", ls_rdata, 32'h0000_1234);
    run(1'b0, 32'h0, 1'b1, 1'b1, 2'd1, 32'hFFFF_FFFE, 32'h0000_BEEF);
    run(1'b0, 32'h0, 1'b1, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_3412);
    run(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk("fetch_wrap", if_data, 32'h3412_BEEF);

    // Reset in the middle of a word store
    @(posedge clk);
    #1;
    ls_rw = 1'b1;  ls_we = 1'b1;  ls_width = 2'd3;  ls_addr = 32'h5000;  ls_wdata = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;  ls_rw = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;  wr_log.delete();
    m_store(32'h5000, 32'h1122_3344, 3);
    last_ld = '0;  n_if = 0;  n_ls = 0;
    @(negedge clk);
    chk("abort_ram_wr", {31'd0, ram_wr}, 32'h0);
    chk("abort_status", {28'd0, if_status, ls_status}, 32'h0);
    chk("abort_ls_rdata", ls_rdata, 32'h0);
    chk("abort_stat_ls", stat_ls_cnt, 32'h0);
    repeat (6) @(negedge clk);
    chk("abort_quiet_bus", wr_log.size(), 0);
    run(1'b1, 32'h1000, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0);

    // Randomized traffic
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 2);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC + $urandom_range(0, 3)
                                      : 32'h100 + $urandom_range(0, 255);
      d = $urandom;
      run(kind != 1, 32'h100 + $urandom_range(0, 255), kind != 0,
          1'($urandom), 2'($urandom), a, d);
    end

    repeat (2) @(negedge clk);
`ifdef MEM_CTRL_STAT_EN
    chk("stat_if_cnt", stat_if_cnt, n_if);
    chk("stat_ls_cnt", stat_ls_cnt, n_ls);
`else
    chk("stat_if_cnt", stat_if_cnt, 32'h0);
    chk("stat_ls_cnt", stat_ls_cnt, 32'h0);
`endif
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
